// File: rtl/iterative_muldiv_pkg.sv
// Shared encodings and helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // MUL never needs signed magnitudes: its low half is sign-agnostic.
  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/iterative_muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface iterative_muldiv_if #(
  parameter int size = 32
) ();

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [size-1:0] A;
  logic [size-1:0] B;
  logic            out_valid;
  logic            out_ready;
  logic [size-1:0] S;
  logic            busy;

  modport master (
    output flush, in_valid, op, A, B, out_ready,
    input  in_ready, out_valid, S, busy
  );

  modport slave (
    input  flush, in_valid, op, A, B, out_ready,
    output in_ready, out_valid, S, busy
  );

endinterface

// File: rtl/iterative_muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step #(
  parameter int size = 32
) (
  input  logic              div_i,
  input  logic [2*size-1:0] acc_i,
  input  logic [size-1:0]   operand_i,
  output logic [2*size-1:0] acc_o
);

  logic [size:0] add_sum;
  logic [size:0] shifted;
  logic [size:0] trial;

  // Multiply keeps the multiplier in the low half; divide keeps {remainder, dividend}.
  always_comb begin
    add_sum = {1'b0, acc_i[2*size-1:size]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    shifted = acc_i[2*size-1:size-1];
    trial   = shifted - {1'b0, operand_i};
    acc_o   = {add_sum, acc_i[size-1:1]};
    if (div_i) begin
      if (trial[size]) begin
        acc_o = {shifted[size-1:0], acc_i[size-2:0], 1'b0};
      end else begin
        acc_o = {trial[size-1:0], acc_i[size-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/iterative_muldiv.sv
// Multi-cycle RV32M multiply/divide unit, one result bit per cycle, with
// valid/ready handshakes and a pipeline-kill flush.
module iterative_muldiv
  import muldiv_pkg::*;
#(
  parameter int size = 32
) (
  input  logic                clk,
  input  logic                reset,
  iterative_muldiv_if.slave   bus
);

  localparam int CW = cnt_width(size);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              special_q, special_d;
  logic [size-1:0]   bmag_q, bmag_d;
  logic [size-1:0]   s_q, s_d;
  logic [2*size-1:0] acc_q, acc_d;
  logic [2*size-1:0] step_acc;

  logic              a_neg, b_neg, div_zero, div_ovf, special_in, neg_in;
  logic [size-1:0]   a_mag, b_mag, special_res, min_val;
  logic [size-1:0]   d_sel, d_res, fix_res;
  logic [2*size-1:0] m_res;

  assign min_val = {1'b1, {(size-1){1'b0}}};

  // Magnitudes of a MIN operand stay correct as unsigned size-bit values.
  always_comb begin
    a_neg       = op_a_signed(bus.op) & bus.A[size-1];
    b_neg       = op_b_signed(bus.op) & bus.B[size-1];
    a_mag       = a_neg ? (~bus.A + 1'b1) : bus.A;
    b_mag       = b_neg ? (~bus.B + 1'b1) : bus.B;
    div_zero    = op_is_div(bus.op) && (bus.B == '0);
    div_ovf     = op_is_div(bus.op) && op_b_signed(bus.op) &&
                  (bus.A == min_val) && (bus.B == '1);
    special_in  = div_zero | div_ovf;
    neg_in      = op_is_rem(bus.op) ? a_neg : (a_neg ^ b_neg);
    special_res = '0;
    if (div_zero) begin
      special_res = op_is_rem(bus.op) ? bus.A : '1;
    end else if (div_ovf) begin
      special_res = op_is_rem(bus.op) ? '0 : min_val;
    end
  end

  muldiv_step #(
    .size(size)
  ) u_step (
    .div_i     (op_is_div(op_q)),
    .acc_i     (acc_q),
    .operand_i (bmag_q),
    .acc_o     (step_acc)
  );

  always_comb begin
    m_res = neg_q ? (~acc_q + 1'b1) : acc_q;
    d_sel = op_is_rem(op_q) ? acc_q[2*size-1:size] : acc_q[size-1:0];
    d_res = neg_q ? (~d_sel + 1'b1) : d_sel;
    if (special_q) begin
      fix_res = acc_q[size-1:0];
    end else if (op_is_div(op_q)) begin
      fix_res = d_res;
    end else if (op_q == OP_MUL) begin
      fix_res = m_res[size-1:0];
    end else begin
      fix_res = m_res[2*size-1:size];
    end
  end

  // Special cases skip CALC but still pass through FIX, so S is only ever
  // written on the way into DONE and their result appears one edge after accept.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    special_d = special_q;
    bmag_d    = bmag_q;
    acc_d     = acc_q;
    s_d       = s_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          op_d   = bus.op;
          neg_d  = neg_in;
          bmag_d = b_mag;
          if (special_in) begin
            special_d = 1'b1;
            acc_d     = {{size{1'b0}}, special_res};
            cnt_d     = '0;
            state_d   = ST_FIX;
          end else begin
            special_d = 1'b0;
            acc_d     = {{size{1'b0}}, a_mag};
            cnt_d     = CW'(size);
            state_d   = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        s_d     = fix_res;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      s_d     = s_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      bmag_q    <= '0;
      acc_q     <= '0;
      s_q       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      bmag_q    <= bmag_d;
      acc_q     <= acc_d;
      s_q       <= s_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.S         = s_q;

endmodule
